// File: rtl/ola_capture_pkg.sv
// Shared types for the logic-analyser capture controller.
// State enum, registered status-flag bundle and the state-to-flag decode.
// Imported by ola_capture_ctrl; ola_capture_count has no dependency on it.
package ola_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_t;

  typedef struct packed {
    logic armed;
    logic triggered;
    logic done;
  } cap_flags_t;

  // Status flags seen by software for a given controller state.
  function automatic cap_flags_t state_flags(input cap_state_t s);
    cap_flags_t f;
    f.armed     = (s == ST_ARMED);
    f.triggered = (s == ST_POST) || (s == ST_DONE);
    f.done      = (s == ST_DONE);
    return f;
  endfunction

endpackage

// File: rtl/ola_capture_count.sv
// Loadable down-counter with zero/last flags, used for pre- and post-trigger counts.
// Latency: count updates one cycle after load/dec/clr; flags are combinational on count.
// Backpressure: none; dec at zero is ignored (counter saturates at zero).
//
// Ports: clock, reset (async active-low), clr (highest priority), load/load_val,
//        dec, count (current value), zero (count==0), last (count==1).
module ola_capture_count #(
  parameter int width = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [width-1:0] load_val,
  input  logic             dec,
  output logic [width-1:0] count,
  output logic             zero,
  output logic             last
);

  localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - one;
    end
  end

  assign zero = (count == '0);
  assign last = (count == one);

endmodule

// File: rtl/ola_capture_ctrl.sv
// Capture controller for an on-chip logic analyser: pre-fill, arm, trigger, post-fill.
// Latency: write strobe/address/data and status flags are registered, one cycle after input.
// Backpressure: none; every qualifying in_valid is written, the sample stream cannot be stalled.
//
// Ports: clock, reset (async active-low); cmd_arm/cmd_abort one-cycle commands;
//        cfg_pre/cfg_post sample counts latched at arm; in_valid/in_sample/in_trigger
//        from the trigger stage; wr_valid/wr_addr/wr_sample to capture memory;
//        trig_addr memory address of the trigger sample; st_armed/st_triggered/st_done.
// Build option: define OLA_CAPTURE_FORCE_EN to add cmd_force, a software trigger that
//        fires on the next in_valid while ARMED.
module ola_capture_ctrl
  import ola_capture_pkg::*;
#(
  parameter int sample_width = 8,
  parameter int addr_width   = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_arm,
  input  logic                    cmd_abort,
`ifdef OLA_CAPTURE_FORCE_EN
  input  logic                    cmd_force,
`endif
  input  logic [addr_width-1:0]   cfg_pre,
  input  logic [addr_width-1:0]   cfg_post,
  input  logic                    in_valid,
  input  logic [sample_width-1:0] in_sample,
  input  logic                    in_trigger,
  output logic                    wr_valid,
  output logic [addr_width-1:0]   wr_addr,
  output logic [sample_width-1:0] wr_sample,
  output logic [addr_width-1:0]   trig_addr,
  output logic                    st_armed,
  output logic                    st_triggered,
  output logic                    st_done
);

  localparam logic [addr_width-1:0] addr_one = {{(addr_width-1){1'b0}}, 1'b1};

  cap_state_t            state, next_state;
  cap_flags_t            flags;
  logic [addr_width-1:0] wr_ptr;
  logic                  write_en;
  logic                  trig_hit;
  logic                  arm_take;
  logic                  trig_take;
  logic                  pre_dec;
  logic                  post_dec;
  logic [addr_width-1:0] pre_count;
  logic [addr_width-1:0] post_count;
  logic                  pre_zero, pre_last;
  logic                  post_zero, post_last;

`ifdef OLA_CAPTURE_FORCE_EN
  // A forced trigger may arrive between samples; it waits for the next
  // in_valid and is dropped once the controller leaves ARMED.
  logic force_pend;

  assign trig_hit = in_valid && (in_trigger || cmd_force || force_pend);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      force_pend <= 1'b0;
    end else if ((state == ST_ARMED) && (next_state == ST_ARMED)) begin
      force_pend <= force_pend | cmd_force;
    end else begin
      force_pend <= 1'b0;
    end
  end
`else
  assign trig_hit = in_valid && in_trigger;
`endif

  // Samples are stored in every capturing state; abort kills the write of
  // the cycle it arrives in.
  assign write_en = in_valid && !cmd_abort &&
                    ((state == ST_PREFILL) || (state == ST_ARMED) || (state == ST_POST));

  always_comb begin
    next_state = state;
    arm_take   = 1'b0;
    trig_take  = 1'b0;
    pre_dec    = 1'b0;
    post_dec   = 1'b0;
    if (cmd_abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (cmd_arm) begin
            arm_take   = 1'b1;
            next_state = (cfg_pre == '0) ? ST_ARMED : ST_PREFILL;
          end
        end
        ST_PREFILL: begin
          if (in_valid) begin
            pre_dec = 1'b1;
            // Count still holds the samples remaining including this one.
            if (pre_last || pre_zero) next_state = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (trig_hit) begin
            trig_take  = 1'b1;
            next_state = post_zero ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (in_valid) begin
            post_dec = 1'b1;
            if (post_last || post_zero) next_state = ST_DONE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  ola_capture_count #(.width(addr_width)) u_pre_count (
    .clock    (clock),
    .reset    (reset),
    .clr      (cmd_abort),
    .load     (arm_take),
    .load_val (cfg_pre),
    .dec      (pre_dec),
    .count    (pre_count),
    .zero     (pre_zero),
    .last     (pre_last)
  );

  ola_capture_count #(.width(addr_width)) u_post_count (
    .clock    (clock),
    .reset    (reset),
    .clr      (cmd_abort),
    .load     (arm_take),
    .load_val (cfg_post),
    .dec      (post_dec),
    .count    (post_count),
    .zero     (post_zero),
    .last     (post_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      flags <= '0;
    end else begin
      state <= next_state;
      flags <= state_flags(next_state);
    end
  end

  // wr_ptr is the address the next sample will take; wr_addr is the
  // registered address of the write currently being presented.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_sample <= '0;
      trig_addr <= '0;
    end else begin
      wr_valid <= write_en;
      if (arm_take) begin
        wr_ptr    <= '0;
        trig_addr <= '0;
      end else if (write_en) begin
        wr_ptr    <= wr_ptr + addr_one;
        wr_addr   <= wr_ptr;
        wr_sample <= in_sample;
        if (trig_take) trig_addr <= wr_ptr;
      end
    end
  end

  assign st_armed     = flags.armed;
  assign st_triggered = flags.triggered;
  assign st_done      = flags.done;

endmodule

// File: tb/tb_ola_capture_ctrl.sv
module tb_ola_capture_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  // Main DUT, addr_width = 10
  logic       cmd_arm, cmd_abort, cmd_force;
  logic [9:0] cfg_pre, cfg_post;
  logic       in_valid, in_trigger;
  logic [7:0] in_sample;
  logic       wr_valid;
  logic [9:0] wr_addr, trig_addr;
  logic [7:0] wr_sample;
  logic       st_armed, st_triggered, st_done;

  // Narrow DUT, addr_width = 4, for address wrap
  logic       arm4, valid4;
  logic [3:0] cfg_pre4, cfg_post4;
  logic [7:0] sample4;
  logic       wr_valid4;
  logic [3:0] wr_addr4, trig_addr4;
  logic [7:0] wr_sample4;
  logic       st_armed4, st_triggered4, st_done4;
  logic       zero_sig;

  ola_capture_ctrl #(.sample_width(8), .addr_width(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_arm      (cmd_arm),
    .cmd_abort    (cmd_abort),
`ifdef OLA_CAPTURE_FORCE_EN
    .cmd_force    (cmd_force),
`endif
    .cfg_pre      (cfg_pre),
    .cfg_post     (cfg_post),
    .in_valid     (in_valid),
    .in_sample    (in_sample),
    .in_trigger   (in_trigger),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_sample    (wr_sample),
    .trig_addr    (trig_addr),
    .st_armed     (st_armed),
    .st_triggered (st_triggered),
    .st_done      (st_done)
  );

  ola_capture_ctrl #(.sample_width(8), .addr_width(4)) dut4 (
    .clock        (clock),
    .reset        (reset),
    .cmd_arm      (arm4),
    .cmd_abort    (zero_sig),
`ifdef OLA_CAPTURE_FORCE_EN
    .cmd_force    (zero_sig),
`endif
    .cfg_pre      (cfg_pre4),
    .cfg_post     (cfg_post4),
    .in_valid     (valid4),
    .in_sample    (sample4),
    .in_trigger   (zero_sig),
    .wr_valid     (wr_valid4),
    .wr_addr      (wr_addr4),
    .wr_sample    (wr_sample4),
    .trig_addr    (trig_addr4),
    .st_armed     (st_armed4),
    .st_triggered (st_triggered4),
    .st_done      (st_done4)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  exp_t em, em4;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int a, input int d);
    exp_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  // Scoreboard monitors: every presented write must match the head of its queue.
  always @(negedge clock) begin
    if (reset && wr_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %0d sample %0d, expected no write", wr_addr, wr_sample);
      end else begin
        em = q.pop_front();
        check("wr_addr", 32'(wr_addr), em.addr);
        check("wr_sample", 32'(wr_sample), em.data);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && wr_valid4) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write4: addr %0d sample %0d, expected no write", wr_addr4, wr_sample4);
      end else begin
        em4 = q4.pop_front();
        check("wr_addr4", 32'(wr_addr4), em4.addr);
        check("wr_sample4", 32'(wr_sample4), em4.data);
      end
    end
  end

  // Drive one cycle of main-DUT inputs starting at a falling edge.
  task automatic cyc(input logic v, input logic [7:0] s, input logic t,
                     input logic a, input logic ab);
    in_valid   = v;
    in_sample  = s;
    in_trigger = t;
    cmd_arm    = a;
    cmd_abort  = ab;
    @(negedge clock);
  endtask

  task automatic cyc4(input logic v, input logic [7:0] s, input logic a);
    valid4  = v;
    sample4 = s;
    arm4    = a;
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_valid"}, 32'(wr_valid), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_sample"}, 32'(wr_sample), 0);
    check({tag, "_trig_addr"}, 32'(trig_addr), 0);
    check({tag, "_st_armed"}, 32'(st_armed), 0);
    check({tag, "_st_triggered"}, 32'(st_triggered), 0);
    check({tag, "_st_done"}, 32'(st_done), 0);
  endtask

  initial begin
    reset = 1'b0;
    cmd_arm = 0; cmd_abort = 0; cmd_force = 0;
    cfg_pre = 0; cfg_post = 0;
    in_valid = 0; in_trigger = 0; in_sample = 0;
    arm4 = 0; valid4 = 0; sample4 = 0; cfg_pre4 = 0; cfg_post4 = 0;
    zero_sig = 0;

    // Reset state
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    check("reset_wr_valid4", 32'(wr_valid4), 0);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // pre=4 post=3, trigger on 6th valid; a stray arm in PREFILL is ignored
    cfg_pre = 4; cfg_post = 3;
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      q.push_back(mk(i, 8'h10 + i));
      cyc(1, 8'(8'h10 + i), (i == 5), (i == 2), 0);
      if (i == 3) check("prefill_to_armed", 32'(st_armed), 1);
      if (i == 4) check("armed_not_triggered", 32'(st_triggered), 0);
    end
    cyc(1, 8'hEE, 1, 0, 0);   // in DONE: must not write
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("t1_st_done", 32'(st_done), 1);
    check("t1_st_triggered", 32'(st_triggered), 1);
    check("t1_st_armed", 32'(st_armed), 0);
    check("t1_trig_addr", 32'(trig_addr), 5);
    check("t1_drained", q.size(), 0);

    // pre=0 post=0, re-armed from DONE, trigger on first valid
    cfg_pre = 0; cfg_post = 0;
    cyc(0, 0, 0, 1, 0);
    check("t2_direct_armed", 32'(st_armed), 1);
    check("t2_done_cleared", 32'(st_done), 0);
    q.push_back(mk(0, 8'h21));
    cyc(1, 8'h21, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("t2_st_done", 32'(st_done), 1);
    check("t2_trig_addr", 32'(trig_addr), 0);
    check("t2_drained", q.size(), 0);

    // Trigger during PREFILL ignored; trigger on 5th valid
    cfg_pre = 4; cfg_post = 1;
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      q.push_back(mk(i, 8'h30 + i));
      cyc(1, 8'(8'h30 + i), (i == 1) || (i == 4), 0, 0);
    end
    cyc(0, 0, 0, 0, 0);
    check("t3_trig_addr", 32'(trig_addr), 4);
    check("t3_st_done", 32'(st_done), 1);
    check("t3_drained", q.size(), 0);

    // Abort in the same cycle as a trigger
    cfg_pre = 0; cfg_post = 2;
    cyc(0, 0, 0, 1, 0);
    q.push_back(mk(0, 8'h41));
    cyc(1, 8'h41, 0, 0, 0);
    cyc(1, 8'h42, 1, 0, 1);
    check("t4_no_write", 32'(wr_valid), 0);
    cyc(0, 0, 0, 0, 0);
    check("t4_st_triggered", 32'(st_triggered), 0);
    check("t4_st_armed", 32'(st_armed), 0);
    check("t4_st_done", 32'(st_done), 0);
    cyc(1, 8'h43, 1, 0, 0);   // IDLE: no write
    cyc(0, 0, 0, 1, 1);       // abort beats arm
    cyc(0, 0, 0, 0, 0);
    check("t4_abort_beats_arm", 32'(st_armed), 0);
    check("t4_drained", q.size(), 0);

    // Reset asserted while in POST
    cfg_pre = 1; cfg_post = 5;
    cyc(0, 0, 0, 1, 0);
    q.push_back(mk(0, 8'h51));
    cyc(1, 8'h51, 0, 0, 0);
    q.push_back(mk(1, 8'h52));
    cyc(1, 8'h52, 1, 0, 0);
    q.push_back(mk(2, 8'h53));
    cyc(1, 8'h53, 0, 0, 0);
    check("t5_in_post", 32'(st_triggered), 1);
    cyc(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clock);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("t5_idle_armed", 32'(st_armed), 0);
    check("t5_idle_trig", 32'(st_triggered), 0);
    cfg_pre = 0; cfg_post = 0;
    cyc(0, 0, 0, 1, 0);
    q.push_back(mk(0, 8'h61));
    cyc(1, 8'h61, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("t5_recapture_done", 32'(st_done), 1);
    check("t5_drained", q.size(), 0);

    // Address wrap on a 4-bit address DUT, never triggered
    cfg_pre4 = 2;
    cyc4(0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      q4.push_back(mk(i % 16, i));
      cyc4(1, 8'(i), 0);
    end
    cyc4(0, 0, 0);
    check("t6_still_armed", 32'(st_armed4), 1);
    check("t6_not_triggered", 32'(st_triggered4), 0);
    check("t6_last_addr", 32'(wr_addr4), 3);
    check("t6_drained", q4.size(), 0);

`ifdef OLA_CAPTURE_FORCE_EN
    // Forced trigger pending until the next valid in ARMED
    cfg_pre = 0; cfg_post = 1;
    cyc(0, 0, 0, 1, 0);
    q.push_back(mk(0, 8'h70));
    cyc(1, 8'h70, 0, 0, 0);
    cmd_force = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cmd_force = 1'b0;
    cyc(0, 0, 0, 0, 0);
    check("t7_still_armed", 32'(st_armed), 1);
    q.push_back(mk(1, 8'h71));
    cyc(1, 8'h71, 0, 0, 0);
    check("t7_forced_trig", 32'(st_triggered), 1);
    q.push_back(mk(2, 8'h72));
    cyc(1, 8'h72, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("t7_trig_addr", 32'(trig_addr), 1);
    check("t7_st_done", 32'(st_done), 1);
    check("t7_drained", q.size(), 0);
`endif

    cyc(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
